vga_frame_scheduler: RTL and testbench
======================================

// Module: vga_frame_scheduler
// PURPOSE
//  Sits between game logic and the VGA drawer. Buffers Mario position updates in a shadow register
//  and applies them to the drawer-facing outputs only on the vertical-sync assertion edge.
//  Round-robins tile-map write requests from two requesters (0 = game logic, 1 = level loader) into
//  a FIFO, drains the FIFO to the background tile store only during vertical blanking, then pulses
//  frame_tick so game logic advances once per frame. This prevents tearing.
// PARAMETERS
//  INIT_X        0    reset value of shadow and live mario_x
//  INIT_Y        0    reset value of shadow and live mario_y
//  MAP_ROWS      12   tile rows; valid row 0..MAP_ROWS-1
//  MAP_COLS      17   tile columns; valid col 0..MAP_COLS-1
//  TQ_DEPTH      8    tile-write FIFO depth, power of two
//  DRAIN_MAX     16   maximum tile writes issued per frame
//  VSYNC_ACTIVE  0    level of vsync while it is asserted
// PORTS
//  vga_clock       in   1    pixel clock; only clock in the block
//  reset           in   1    asynchronous, active-low reset
//  vsync           in   1    vsync from the signal generator, same clock domain
//  pos_valid       in   1    new position offered
//  pos_x, pos_y    in   32   signed (int) new position
//  pos_ready       out  1    always 1 once out of reset
//  treq_valid      in   2    per-requester tile-write request
//  treq_row        in   2x4  requested tile row
//  treq_col        in   2x5  requested tile column
//  treq_val        in   2x8  requested tile code (BDR/SKY/BLK/GND)
//  treq_ready      out  2    grant; a transfer occurs when valid & ready
//  mario_x, mario_y out 32   live position fed to the drawer
//  tile_we         out  1    tile-store write strobe
//  tile_row        out  4    write address, row
//  tile_col        out  5    write address, column
//  tile_val        out  8    write data
//  frame_tick      out  1    one-cycle pulse per frame
//  frame_count     out  16   frames completed; wraps 0xFFFF -> 0
//  range_err       out  1    sticky: an out-of-range tile request was seen
// BEHAVIOUR
//  Reset (async, reset=0): mario_x/y and shadow = INIT_X/INIT_Y; FIFO empty; rr pointer = 0;
//   tile_we, frame_tick and range_err = 0; frame_count = 0; tile_row/col/val = 0; state IDLE.
//  vsync edge: vs_q registered each cycle. vs_start = (vsync==VSYNC_ACTIVE) & (vs_q!=VSYNC_ACTIVE).
//  Position: pos_valid loads the shadow on the same edge; the latest value wins; there is no queue.
//  Tile arbitration: at most one push per cycle, and only when the FIFO is not full.
//   - One requester valid: it is granted.
//   - Both valid: requester rr is granted; rr then flips to the other requester.
//   - FIFO full: treq_ready = 0 for both.
//   - treq_ready is combinational from valid, full and rr.
//   - Out-of-range row/col: request is granted but not pushed; range_err is set.
//  FSM:
//   IDLE   -> COMMIT on vs_start.
//   COMMIT (1 cycle) -> DRAIN. mario_x/y <= shadow as it was before this edge. A pos_valid
//          in the same cycle goes to the shadow and takes effect next frame.
//   DRAIN  One pop per cycle; tile_we=1 with the popped entry registered, so output lags the pop
//          by 1 cycle. Exit to TICK when the FIFO is empty or DRAIN_MAX pops are done.
//          Leftover entries wait for the next frame.
//   TICK   (1 cycle) frame_tick=1, frame_count+=1 -> IDLE.
//  Pushes stay legal in every state; a simultaneous push and pop in DRAIN keeps the count unchanged.
//  A pop is only permitted in DRAIN.
//  A vs_start that arrives outside IDLE is ignored; no frame is queued.
//  Reset during DRAIN flushes the FIFO; the undrained writes are lost, by design.
//  Worst-case latency from vs_start to frame_tick = DRAIN_MAX + 3 cycles.
// STRUCTURE
//  vga_pkg: BDR/SKY/BLK/GND tile codes, MAP_ROWS/MAP_COLS, and
//   typedef struct packed {logic[3:0] row; logic[4:0] col; logic[7:0] val;} tile_wr_t.
//  FSM state enum sched_state_t {IDLE, COMMIT, DRAIN, TICK} is local to this module.
//  One sub-module, tile_wr_fifo: sync FIFO of tile_wr_t with push/pop/full/empty/count and the
//   same async active-low reset.
// TESTING
//  1 Reset with INIT_X=10, INIT_Y=20 -> mario_x=10, mario_y=20, frame_count=0, all strobes 0.
//  2 pos_valid with (100,200) mid-frame, then vsync falls -> mario_x/y stay old until COMMIT,
//    then become 100/200; frame_tick 3 cycles after vs_start with an empty FIFO.
//  3 Both requesters hold valid for 4 cycles, FIFO empty -> grants alternate 0,1,0,1. Next frame
//    emits 4 tile_we pulses in that order, then frame_tick; frame_count=1.
//  4 Push 8 entries with TQ_DEPTH=8 -> treq_ready=0 on the 9th. Set DRAIN_MAX=5: the frame drains
//    5 entries, 3 remain, and the next frame drains the remaining 3.
//  5 Request with row=12, col=3 -> granted, no tile_we issued, range_err=1 until reset.
//  6 Assert reset during DRAIN with 4 entries left -> FIFO empty, tile_we=0, state IDLE, no frame_tick.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: tile codes, map geometry and the tile-write record shared by the frame scheduler
package vga_pkg;
  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;
  localparam int MAP_ROWS = 12;
  localparam int MAP_COLS = 17;
  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
    logic [7:0] val;
  } tile_wr_t;
endpackage

// File: rtl/tile_wr_fifo.sv
// tile_wr_fifo: first-word-fall-through sync FIFO of tile writes
module tile_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     vga_clock,
  input  logic     reset,
  input  logic     push,
  input  tile_wr_t din,
  input  logic     pop,
  output tile_wr_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  tile_wr_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    dout = mem_q[rd_q];
  end
  always_ff @(posedge vga_clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge vga_clock)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: commits Mario's position on vsync and drains queued tile writes during blanking
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int   INIT_X       = 0,
  parameter int   INIT_Y       = 0,
  parameter int   MAP_ROWS     = vga_pkg::MAP_ROWS,
  parameter int   MAP_COLS     = vga_pkg::MAP_COLS,
  parameter int   TQ_DEPTH     = 8,
  parameter int   DRAIN_MAX    = 16,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               vsync,
  input  logic               pos_valid,
  input  logic signed [31:0] pos_x,
  input  logic signed [31:0] pos_y,
  output logic               pos_ready,
  input  logic [1:0]         treq_valid,
  input  logic [1:0][3:0]    treq_row,
  input  logic [1:0][4:0]    treq_col,
  input  logic [1:0][7:0]    treq_val,
  output logic [1:0]         treq_ready,
  output logic signed [31:0] mario_x,
  output logic signed [31:0] mario_y,
  output logic               tile_we,
  output logic [3:0]         tile_row,
  output logic [4:0]         tile_col,
  output logic [7:0]         tile_val,
  output logic               frame_tick,
  output logic [15:0]        frame_count,
  output logic               range_err
);
  typedef enum logic [1:0] {IDLE, COMMIT, DRAIN, TICK} sched_state_t;
  localparam int PW = $clog2(DRAIN_MAX + 1);
  sched_state_t state_q, state_d;
  logic vs_q, rr_q, rr_d, rdy_q, err_q, err_d, we_q, we_d;
  logic signed [31:0] sx_q, sx_d, sy_q, sy_d, mx_q, mx_d, my_q, my_d;
  logic [PW-1:0] pops_q, pops_d;
  logic [15:0] fc_q, fc_d;
  tile_wr_t out_q, out_d, push_data, pop_data;
  logic vs_start, commit, pop, push, gnt, fifo_full, fifo_empty;
  logic [1:0] in_rng;
  tile_wr_fifo #(.DEPTH(TQ_DEPTH)) u_fifo (
    .vga_clock(vga_clock),
    .reset(reset),
    .push(push),
    .din(push_data),
    .pop(pop),
    .dout(pop_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // Out-of-range requests are still granted so a bad requester cannot stall the arbiter
  always_comb begin
    for (int i = 0; i < 2; i++)
      in_rng[i] = int'(treq_row[i]) < MAP_ROWS && int'(treq_col[i]) < MAP_COLS;
    treq_ready = fifo_full ? 2'b00 : &treq_valid ? (rr_q ? 2'b10 : 2'b01) : treq_valid;
    gnt = treq_ready[1];
    push = |treq_ready && in_rng[gnt];
    push_data = '{row: treq_row[gnt], col: treq_col[gnt], val: treq_val[gnt]};
    rr_d = rr_q ^ (&treq_valid && !fifo_full);
    err_d = err_q || (|treq_ready && !in_rng[gnt]);
    vs_start = (vsync == VSYNC_ACTIVE) && (vs_q != VSYNC_ACTIVE);
  end
  always_ff @(posedge vga_clock or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_start) state_d = COMMIT;
      COMMIT:  state_d = DRAIN;
      DRAIN:   if (!pop) state_d = TICK;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    commit = state_q == COMMIT;
    pop = state_q == DRAIN && !fifo_empty && pops_q < PW'(DRAIN_MAX);
    frame_tick = state_q == TICK;
  end
  // The live position takes the shadow as it stood before the commit edge
  always_comb begin
    sx_d = pos_valid ? pos_x : sx_q;
    sy_d = pos_valid ? pos_y : sy_q;
    mx_d = commit ? sx_q : mx_q;
    my_d = commit ? sy_q : my_q;
    pops_d = commit ? '0 : pops_q + PW'(pop);
    we_d = pop;
    out_d = pop ? pop_data : out_q;
    fc_d = fc_q + 16'(frame_tick);
  end
  always_ff @(posedge vga_clock or negedge reset)
    if (!reset) begin
      vs_q <= VSYNC_ACTIVE;
      rr_q <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      sx_q <= INIT_X;
      sy_q <= INIT_Y;
      mx_q <= INIT_X;
      my_q <= INIT_Y;
      pops_q <= '0;
      fc_q <= '0;
      out_q <= '0;
    end else begin
      vs_q <= vsync;
      rr_q <= rr_d;
      rdy_q <= 1'b1;
      err_q <= err_d;
      we_q <= we_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      mx_q <= mx_d;
      my_q <= my_d;
      pops_q <= pops_d;
      fc_q <= fc_d;
      out_q <= out_d;
    end
  assign pos_ready = rdy_q;
  assign mario_x = mx_q;
  assign mario_y = my_q;
  assign tile_we = we_q;
  assign tile_row = out_q.row;
  assign tile_col = out_q.col;
  assign tile_val = out_q.val;
  assign frame_count = fc_q;
  assign range_err = err_q;
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: arbitration vector table, directed frame sequences and random traffic
// checked against a queue-based model of the frame schedule
module tb_vga_frame_scheduler;
  import vga_pkg::*;
  localparam int DM = 5, TQ = 8, IX = 10, IY = 20;
  logic vga_clock = 0, reset = 1, vsync = 1, pos_valid = 0;
  logic signed [31:0] pos_x = 0, pos_y = 0, mario_x, mario_y;
  logic pos_ready, tile_we, frame_tick, range_err;
  logic [1:0] treq_valid = 0, treq_ready;
  logic [1:0][3:0] treq_row = '0;
  logic [1:0][4:0] treq_col = '0;
  logic [1:0][7:0] treq_val = '0;
  logic [3:0] tile_row;
  logic [4:0] tile_col;
  logic [7:0] tile_val;
  logic [15:0] frame_count;
  int n_chk = 0, n_fail = 0;
  tile_wr_t q[$];
  bit rr, rerr;
  int sx, sy, lx, ly, frames;
  typedef struct {logic [1:0] v; logic [1:0] exp;} vec_t;
  vec_t tbl[16];

  vga_frame_scheduler #(.INIT_X(IX), .INIT_Y(IY), .TQ_DEPTH(TQ), .DRAIN_MAX(DM)) dut (
    .vga_clock(vga_clock), .reset(reset), .vsync(vsync), .pos_valid(pos_valid),
    .pos_x(pos_x), .pos_y(pos_y), .pos_ready(pos_ready), .treq_valid(treq_valid),
    .treq_row(treq_row), .treq_col(treq_col), .treq_val(treq_val), .treq_ready(treq_ready),
    .mario_x(mario_x), .mario_y(mario_y), .tile_we(tile_we), .tile_row(tile_row),
    .tile_col(tile_col), .tile_val(tile_val), .frame_tick(frame_tick),
    .frame_count(frame_count), .range_err(range_err)
  );

  always #5 vga_clock = ~vga_clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic tile_wr_t mk(input int r, input int c, input int v);
    mk = '{row: 4'(r), col: 5'(c), val: 8'(v)};
  endfunction

  task automatic do_reset();
    reset = 0;
    treq_valid = 0;
    pos_valid = 0;
    vsync = 1;
    q.delete();
    rr = 0;
    rerr = 0;
    sx = IX; sy = IY; lx = IX; ly = IY;
    frames = 0;
    #2;
    check("rst_mario_x", mario_x, IX);
    check("rst_mario_y", mario_y, IY);
    check("rst_tile_we", tile_we, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_range_err", range_err, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_tile_addr", {tile_row, tile_col, tile_val}, 0);
    @(negedge vga_clock);
    reset = 1;
    @(negedge vga_clock);
    check("pos_ready", pos_ready, 1);
  endtask

  // One idle-frame cycle: offer requests/position, check grant and the quiet outputs
  task automatic req_cycle(input logic [1:0] v, input tile_wr_t e0, input tile_wr_t e1,
                           input bit use_tbl, input logic [1:0] tbl_exp,
                           input bit pv, input int px, input int py);
    logic [1:0] m;
    tile_wr_t g;
    m = (q.size() >= TQ) ? 2'b00 : (v == 2'b11) ? (rr ? 2'b10 : 2'b01) : v;
    treq_valid = v;
    treq_row = {e1.row, e0.row};
    treq_col = {e1.col, e0.col};
    treq_val = {e1.val, e0.val};
    pos_valid = pv; pos_x = px; pos_y = py;
    #1;
    check("treq_ready", treq_ready, use_tbl ? tbl_exp : m);
    if (m != 2'b00) begin
      g = m[1] ? e1 : e0;
      if (int'(g.row) < MAP_ROWS && int'(g.col) < MAP_COLS) q.push_back(g);
      else rerr = 1;
      if (v == 2'b11) rr = ~rr;
    end
    if (pv) begin sx = px; sy = py; end
    @(negedge vga_clock);
    treq_valid = 0;
    pos_valid = 0;
    check("range_err", range_err, rerr);
    check("idle_tile_we", tile_we, 0);
    check("idle_frame_tick", frame_tick, 0);
    check("idle_mario_x", mario_x, lx);
    check("idle_mario_y", mario_y, ly);
  endtask

  // Frame from vs_start: commit after 2 edges, drain min(queued, DM) writes, tick after the drain.
  // A second vsync edge during the drain must be ignored.
  task automatic run_frame();
    int n, p;
    tile_wr_t e;
    n = q.size() < DM ? q.size() : DM;
    p = int'($urandom);
    vsync = 0;
    for (int t = 1; t <= DM + 5; t++) begin
      @(negedge vga_clock);
      if (t == 2) begin lx = sx; ly = sy; sx = p; sy = -p; end
      check("mario_x", mario_x, lx);
      check("mario_y", mario_y, ly);
      pos_valid = (t == 1); pos_x = p; pos_y = -p;
      vsync = (t != 3);
      check("tile_we", tile_we, t >= 3 && t < 3 + n);
      if (t >= 3 && t < 3 + n) begin
        e = q.pop_front();
        check("tile_data", {tile_row, tile_col, tile_val}, e);
      end
      check("frame_tick", frame_tick, t == 3 + n);
    end
    pos_valid = 0;
    vsync = 1;
    frames++;
    check("frame_count", frame_count, frames);
  endtask

  initial begin
    tbl[0] = '{2'b00, 2'b00};
    for (int i = 1; i <= 4; i++) tbl[i] = '{2'b11, (i % 2) ? 2'b01 : 2'b10};
    tbl[5] = '{2'b10, 2'b10};
    tbl[6] = '{2'b01, 2'b01};
    tbl[7] = '{2'b11, 2'b01};
    for (int i = 8; i <= 12; i++) tbl[i] = '{2'b01, 2'b01};
    tbl[13] = '{2'b01, 2'b00};
    tbl[14] = '{2'b11, 2'b00};
    tbl[15] = '{2'b10, 2'b00};
    #1;
    do_reset();
    req_cycle(2'b00, '0, '0, 0, 2'b00, 1, 100, 200);
    repeat (2) req_cycle(2'b00, '0, '0, 0, 2'b00, 0, 0, 0);
    run_frame();
    for (int i = 0; i < 5; i++)
      req_cycle(tbl[i].v, mk(i % 12, i, 2 * i), mk((i + 1) % 12, 16 - i, 2 * i + 1), 1, tbl[i].exp, 0, 0, 0);
    run_frame();
    for (int i = 5; i < 16; i++)
      req_cycle(tbl[i].v, mk(i % 12, i, 2 * i), mk((i + 1) % 12, 16 - i, 2 * i + 1), 1, tbl[i].exp, 0, 0, 0);
    run_frame();
    run_frame();
    req_cycle(2'b01, mk(12, 3, GND), '0, 1, 2'b01, 0, 0, 0);
    run_frame();
    req_cycle(2'b00, '0, '0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 6; i++) req_cycle(2'b01, mk(i, i + 2, SKY + i), '0, 0, 2'b00, 0, 0, 0);
    vsync = 0;
    repeat (3) @(negedge vga_clock);
    check("drain_before_rst", tile_we, 1);
    vsync = 1;
    #2;
    do_reset();
    repeat (3) req_cycle(2'b00, '0, '0, 0, 2'b00, 0, 0, 0);
    run_frame();
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(1, 12))
        req_cycle(2'($urandom), mk($urandom_range(0, 12), $urandom_range(0, 17), $urandom),
                  mk($urandom_range(0, 12), $urandom_range(0, 17), $urandom), 0, 2'b00,
                  1'($urandom), int'($urandom), int'($urandom));
      run_frame();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
